bus_master_arbiter: RTL and testbench

Round-robin scheduler that shares the system bus master port 1 (the `d1_*` interface of the bus top) among `NUM_REQ` local requesters. It arbitrates pending requests and drives one bus transaction at a time: a one-cycle `d1_valid` issue, then tracking of `d1_ready` through acknowledge and completion. It returns read data and a completion pulse to the winning requester, with a watchdog timeout so a hung slave cannot lock the port.

---
 rtl/bus_master_arbiter.sv | 159 +++++++++++++++
 tb/tb_bus_master_arbiter.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_master_arbiter.sv
// Round-robin arbiter sharing one bus master port among NUM_REQ requesters.
// One transaction at a time: issue strobe, ack/done tracking on d1_ready, watchdog abort.
module bus_master_arbiter #(
    parameter int unsigned NUM_REQ        = 2,
    parameter int unsigned ADDR_WIDTH     = 16,
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic [NUM_REQ-1:0]               req_i,
    input  logic [NUM_REQ-1:0]               req_mode_i,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata_i,
    output logic [NUM_REQ-1:0]               grant_o,
    output logic [NUM_REQ-1:0]               done_o,
    output logic [DATA_WIDTH-1:0]            rdata_o,
    output logic                             timeout_err_o,
    output logic                             busy_o,
    output logic [ADDR_WIDTH-1:0]            d1_addr_o,
    output logic [DATA_WIDTH-1:0]            d1_wdata_o,
    output logic                             d1_mode_o,
    output logic                             d1_valid_o,
    input  logic                             d1_ready_i,
    input  logic [DATA_WIDTH-1:0]            d1_rdata_i,
    input  logic                             s_ready_i
);

    localparam int unsigned IdxW = $clog2(NUM_REQ);
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IdxW-1:0] LastRst = IdxW'(NUM_REQ - 1);
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);
    localparam logic [CntW-1:0] CntMax  = '1;

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWaitAck,
        StWaitDone,
        StComplete
    } state_e;

    state_e                  state_q;
    logic [NUM_REQ-1:0]      grant_q;
    logic [NUM_REQ-1:0]      done_q;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic                    timeout_err_q;
    logic                    busy_q;
    logic [ADDR_WIDTH-1:0]   d1_addr_q;
    logic [DATA_WIDTH-1:0]   d1_wdata_q;
    logic                    d1_mode_q;
    logic                    d1_valid_q;
    logic [IdxW-1:0]         last_q;
    logic [IdxW-1:0]         sel_q;
    logic [CntW-1:0]         cnt_q;

    logic [IdxW-1:0]         cand;
    logic [IdxW-1:0]         win_idx;
    logic                    win_vld;
    logic                    waiting;
    logic                    fin_ok;
    logic                    fin_tmo;

    // First pending request searching upward from last_q+1, wrapping at NUM_REQ.
    always_comb begin
        cand    = '0;
        win_idx = '0;
        win_vld = 1'b0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = IdxW'((32'(last_q) + k) % NUM_REQ);
            if (!win_vld && req_i[cand]) begin
                win_vld = 1'b1;
                win_idx = cand;
            end
        end
    end

    // A real completion in WAIT_DONE beats the watchdog; in WAIT_ACK the watchdog wins.
    always_comb begin
        waiting = (state_q == StWaitAck) || (state_q == StWaitDone);
        fin_ok  = (state_q == StWaitDone) && d1_ready_i;
        fin_tmo = waiting && !fin_ok && (cnt_q >= CntLast);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= StIdle;
            grant_q       <= '0;
            done_q        <= '0;
            rdata_q       <= '0;
            timeout_err_q <= 1'b0;
            busy_q        <= 1'b0;
            d1_addr_q     <= '0;
            d1_wdata_q    <= '0;
            d1_mode_q     <= 1'b0;
            d1_valid_q    <= 1'b0;
            last_q        <= LastRst;
            sel_q         <= '0;
            cnt_q         <= '0;
        end else begin
            if (waiting && (cnt_q != CntMax)) begin
                cnt_q <= cnt_q + CntW'(1);
            end
            unique case (state_q)
                StIdle: begin
                    if (win_vld && d1_ready_i && s_ready_i) begin
                        sel_q      <= win_idx;
                        grant_q    <= NUM_REQ'(1) << win_idx;
                        d1_addr_q  <= req_addr_i[win_idx*ADDR_WIDTH +: ADDR_WIDTH];
                        d1_wdata_q <= req_wdata_i[win_idx*DATA_WIDTH +: DATA_WIDTH];
                        d1_mode_q  <= req_mode_i[win_idx];
                        d1_valid_q <= 1'b1;
                        busy_q     <= 1'b1;
                        cnt_q      <= '0;
                        state_q    <= StIssue;
                    end
                end
                StIssue: begin
                    d1_valid_q <= 1'b0;
                    state_q    <= StWaitAck;
                end
                StWaitAck, StWaitDone: begin
                    if (fin_ok || fin_tmo) begin
                        done_q        <= grant_q;
                        last_q        <= sel_q;
                        timeout_err_q <= fin_tmo;
                        state_q       <= StComplete;
                        if (fin_tmo) begin
                            rdata_q <= '0;
                        end else if (!d1_mode_q) begin
                            rdata_q <= d1_rdata_i;
                        end
                    end else if ((state_q == StWaitAck) && !d1_ready_i) begin
                        state_q <= StWaitDone;
                    end
                end
                StComplete: begin
                    done_q        <= '0;
                    timeout_err_q <= 1'b0;
                    grant_q       <= '0;
                    busy_q        <= 1'b0;
                    state_q       <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign grant_o       = grant_q;
    assign done_o        = done_q;
    assign rdata_o       = rdata_q;
    assign timeout_err_o = timeout_err_q;
    assign busy_o        = busy_q;
    assign d1_addr_o     = d1_addr_q;
    assign d1_wdata_o    = d1_wdata_q;
    assign d1_mode_o     = d1_mode_q;
    assign d1_valid_o    = d1_valid_q;

endmodule

// File: tb/tb_bus_master_arbiter.sv
// Randomized scoreboard bench for bus_master_arbiter: a reference model predicts service
// order and results per batch; a monitor checks each issue and completion against the queue.
module tb_bus_master_arbiter;

    localparam int N  = 3;
    localparam int AW = 16;
    localparam int DW = 8;
    localparam int T  = 8;

    typedef struct {
        int          idx;
        logic        mode;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        bit          tmo;
        logic [DW-1:0] rdata;
        int          lat;
    } exp_t;

    typedef struct {
        int          a;
        int          b;
        int          hang;
        logic [DW-1:0] rd;
    } beh_t;

    typedef struct {
        logic        mode;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } fld_t;

    logic            clk;
    logic            rst;
    logic [N-1:0]    req;
    logic [N-1:0]    req_mode;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [N-1:0]    grant;
    logic [N-1:0]    done;
    logic [DW-1:0]   rdata;
    logic            timeout_err;
    logic            busy;
    logic [AW-1:0]   d1_addr;
    logic [DW-1:0]   d1_wdata;
    logic            d1_mode;
    logic            d1_valid;
    logic            d1_ready;
    logic [DW-1:0]   d1_rdata;
    logic            s_ready;

    logic            s_seen;
    logic            r_seen;

    exp_t exp_q[$];
    beh_t beh_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   m_last = N - 1;
    logic [DW-1:0] m_rdata = '0;

    bus_master_arbiter #(
        .NUM_REQ        (N),
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .req_i         (req),
        .req_mode_i    (req_mode),
        .req_addr_i    (req_addr),
        .req_wdata_i   (req_wdata),
        .grant_o       (grant),
        .done_o        (done),
        .rdata_o       (rdata),
        .timeout_err_o (timeout_err),
        .busy_o        (busy),
        .d1_addr_o     (d1_addr),
        .d1_wdata_o    (d1_wdata),
        .d1_mode_o     (d1_mode),
        .d1_valid_o    (d1_valid),
        .d1_ready_i    (d1_ready),
        .d1_rdata_i    (d1_rdata),
        .s_ready_i     (s_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        s_seen <= s_ready;
        r_seen <= d1_ready;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int idx_of(input logic [N-1:0] v);
        int r;
        r = 0;
        for (int i = 0; i < N; i++) if (v[i]) r = i;
        return r;
    endfunction

    function automatic fld_t rand_fld();
        fld_t f;
        f.mode  = 1'($urandom_range(1, 0));
        f.addr  = AW'($urandom);
        f.wdata = DW'($urandom);
        return f;
    endfunction

    // Bus slave model: per issued transaction, replay the next scripted behaviour.
    initial begin : bus
        beh_t b;
        d1_ready = 1'b1;
        d1_rdata = '0;
        forever begin
            @(negedge clk);
            if (d1_valid && !rst) begin
                if (beh_q.size() == 0) begin
                    chk("bus_script_empty", 64'(beh_q.size()), 64'd1);
                    b.a = 1; b.b = 1; b.hang = 0; b.rd = '0;
                end else begin
                    b = beh_q.pop_front();
                end
                repeat (b.a) @(negedge clk);
                if (b.hang != 1) begin
                    d1_ready = 1'b0;
                    d1_rdata = DW'($urandom);
                end
                if (b.hang != 0) begin
                    for (int w = 0; w < 200 && done == '0 && !rst; w++) @(negedge clk);
                end else begin
                    repeat (b.b) @(negedge clk);
                end
                d1_ready = 1'b1;
                d1_rdata = b.rd;
            end
        end
    end

    // Monitor: checks issues and completions against the expected queue.
    initial begin : mon
        int            cyc;
        int            t_iss;
        bit            in_tx;
        bit            prev_valid;
        logic [AW-1:0] h_addr;
        logic [DW-1:0] h_wdata;
        logic          h_mode;
        exp_t          e;
        cyc = 0; t_iss = 0; in_tx = 0; prev_valid = 0;
        h_addr = '0; h_wdata = '0; h_mode = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst) begin
                chk("grant_onehot", 64'($countones(grant) <= 1), 64'd1);
                chk("busy_vs_grant", 64'(busy), 64'(|grant));
                if (!busy) in_tx = 0;
                if (d1_valid) begin
                    chk("issue_gate", 64'(s_seen & r_seen), 64'd1);
                    chk("valid_one_cycle", 64'(prev_valid), 64'd0);
                    if (exp_q.size() == 0) begin
                        chk("unexpected_issue", 64'(exp_q.size()), 64'd1);
                    end else begin
                        e = exp_q[0];
                        chk("issue_grant", 64'(grant), 64'd1 << e.idx);
                        chk("issue_addr", 64'(d1_addr), 64'(e.addr));
                        chk("issue_mode", 64'(d1_mode), 64'(e.mode));
                        chk("issue_wdata", 64'(d1_wdata), 64'(e.wdata));
                    end
                    in_tx = 1; t_iss = cyc;
                    h_addr = d1_addr; h_wdata = d1_wdata; h_mode = d1_mode;
                end else if (in_tx) begin
                    chk("hold_fields", {d1_mode, d1_wdata, d1_addr}, {h_mode, h_wdata, h_addr});
                end
                if (done != '0) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_done", 64'(done), 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("done_onehot", 64'(done), 64'd1 << e.idx);
                        chk("done_grant", 64'(grant), 64'(done));
                        chk("rdata", 64'(rdata), 64'(e.rdata));
                        chk("timeout_err", 64'(timeout_err), 64'(e.tmo));
                        chk("latency", 64'(cyc - t_iss), 64'(e.lat));
                    end
                end else begin
                    chk("tmo_without_done", 64'(timeout_err), 64'd0);
                end
            end
            prev_valid = d1_valid;
        end
    end

    // One batch: requesters in mask each want 1-2 transactions; model predicts order/results.
    task automatic run_batch(input logic [N-1:0] mask, input bit allow_tmo, input int gate);
        int   cnt[N];
        int   pos[N];
        int   rem[N];
        fld_t fl[N][2];
        fld_t f;
        int   ptr, c, g, guard;
        beh_t b;
        exp_t e;
        for (int i = 0; i < N; i++) begin
            cnt[i] = mask[i] ? int'($urandom_range(2, 1)) : 0;
            pos[i] = 0;
            rem[i] = cnt[i];
            fl[i][0] = rand_fld();
            fl[i][1] = rand_fld();
        end
        ptr = m_last;
        forever begin
            c = -1;
            for (int k = 1; k <= N; k++) begin
                int j;
                j = (ptr + k) % N;
                if (c < 0 && rem[j] > 0) c = j;
            end
            if (c < 0) break;
            rem[c]--;
            f = fl[c][cnt[c] - 1 - rem[c]];
            b.a = int'($urandom_range(3, 1));
            b.b = int'($urandom_range(3, 1));
            b.hang = (allow_tmo && $urandom_range(5, 0) == 0) ? int'($urandom_range(2, 1)) : 0;
            b.rd = DW'($urandom);
            e.idx = c; e.mode = f.mode; e.addr = f.addr; e.wdata = f.wdata;
            e.tmo = (b.hang != 0);
            e.rdata = e.tmo ? '0 : (f.mode ? m_rdata : b.rd);
            e.lat = e.tmo ? T + 1 : b.a + b.b + 1;
            m_rdata = e.rdata;
            beh_q.push_back(b);
            exp_q.push_back(e);
            ptr = c;
        end
        m_last = ptr;

        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            if (mask[i]) begin
                req_mode[i] = fl[i][0].mode;
                req_addr[i*AW +: AW] = fl[i][0].addr;
                req_wdata[i*DW +: DW] = fl[i][0].wdata;
            end
        end
        req = mask;
        if (gate > 0) begin
            s_ready = 1'b0;
            repeat (gate) @(negedge clk);
            chk("gated_no_issue", 64'(busy), 64'd0);
            s_ready = 1'b1;
            @(negedge clk);
            chk("issue_after_gate", 64'(d1_valid), 64'd1);
        end
        guard = 0;
        while ((req != '0 || exp_q.size() != 0) && guard < 3000) begin
            if (d1_valid) begin
                // Served requester's inputs change mid-service; latched fields must not.
                g = idx_of(grant);
                req_mode[g] = ~req_mode[g];
                req_addr[g*AW +: AW] = AW'($urandom);
                req_wdata[g*DW +: DW] = DW'($urandom);
            end
            if (done != '0) begin
                g = idx_of(done);
                pos[g]++;
                if (pos[g] < cnt[g]) begin
                    req_mode[g] = fl[g][pos[g]].mode;
                    req_addr[g*AW +: AW] = fl[g][pos[g]].addr;
                    req_wdata[g*DW +: DW] = fl[g][pos[g]].wdata;
                end else begin
                    req[g] = 1'b0;
                end
            end
            s_ready = ($urandom_range(9, 0) < 7);
            @(negedge clk);
            guard++;
        end
        chk("batch_drained", 64'(guard < 3000), 64'd1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_grant"}, 64'(grant), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_rdata"}, 64'(rdata), 64'd0);
        chk({tag, "_tmo"}, 64'(timeout_err), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_valid"}, 64'(d1_valid), 64'd0);
        chk({tag, "_mode"}, 64'(d1_mode), 64'd0);
        chk({tag, "_addr"}, 64'(d1_addr), 64'd0);
        chk({tag, "_wdata"}, 64'(d1_wdata), 64'd0);
    endtask

    initial begin : stim
        int   guard;
        exp_t e;
        beh_t b;
        rst = 1'b1; req = '0; req_mode = '0; req_addr = '0; req_wdata = '0; s_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;

        run_batch(N'(1), 1'b0, 10);
        for (int it = 0; it < 40; it++) begin
            run_batch(N'($urandom_range((1 << N) - 1, 1)), 1'b1, 0);
        end

        // Reset while the transaction sits in WAIT_DONE: no done, outputs cleared.
        e.idx = 0; e.mode = 1'b0; e.addr = AW'($urandom); e.wdata = DW'($urandom);
        e.tmo = 0; e.rdata = '0; e.lat = 0;
        b.a = 1; b.b = 3; b.hang = 0; b.rd = DW'($urandom);
        exp_q.push_back(e);
        beh_q.push_back(b);
        @(negedge clk);
        s_ready = 1'b1;
        req_mode[0] = 1'b0; req_addr[0 +: AW] = e.addr; req_wdata[0 +: DW] = e.wdata;
        req = N'(1);
        guard = 0;
        while (!d1_valid && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        chk("rst_test_issue", 64'(d1_valid), 64'd1);
        repeat (2) @(negedge clk);
        chk("busy_before_rst", 64'(busy), 64'd1);
        rst = 1'b1;
        req = '0;
        exp_q.delete();
        @(negedge clk);
        chk_all_zero("midrst");
        rst = 1'b0;
        m_last = N - 1;
        m_rdata = '0;
        run_batch(N'(3), 1'b0, 0);

        repeat (4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got running, expected finished");
        $fatal(1, "watchdog expired");
    end

endmodule
